cbfp_stage0: RTL and testbench
==============================

// Module: cbfp_stage0
// PURPOSE
// - Convergent block floating-point (CBFP) normaliser after an FFT butterfly stage.
// - Takes two complex streams, p and n, each 16 lanes x 23 bit per beat; a block is 4 valid beats (64 samples/stream).
// - Per stream and block: finds the minimum redundant-sign-bit count over all re+im values, shifts the block left by it, keeps the top 11 bits.
// - Replays the normalised p block, then the n block, on one 16-lane complex output bus.
// PARAMETERS
// - cnt_size      5   width of redundant-sign-bit count / shift amount
// - array_size    16  lanes per beat
// - din_size      23  input sample width (signed)
// - dout_size     11  output sample width (signed)
// - buffer_depth  64  samples per stream per block (array_size*4 beats)
// PORTS
// - clk        in   1                 single clock, rising edge
// - rstn       in   1                 asynchronous active-low reset
// - valid_in   in   1                 din_* carries one beat this cycle
// - din_re_p   in   [16][23] signed   p stream real
// - din_im_p   in   [16][23] signed   p stream imag
// - din_re_n   in   [16][23] signed   n stream real
// - din_im_n   in   [16][23] signed   n stream imag
// - dout_mux_re out [16][11] signed   normalised real (p beats then n beats)
// - dout_mux_im out [16][11] signed   normalised imag
// - valid_out  out  1                 dout_mux_* valid this cycle
// BEHAVIOUR
// - Reset (async, rstn=0): valid_out=0, all dout_mux_* =0, beat counter=0, pending blocks discarded, min-count regs=22.
// - Input: 2-bit beat counter advances only on valid_in=1; beats need not be consecutive; beat k writes lanes to buffer addr k*16+lane.
// - Count: redundant sign bits = leading bits equal to MSB, minus 1; range 0..22 (0 and -1 give 22).
// - Running min kept per stream over re and im; finalised on the 4th valid beat, then reset to 22.
// - Storage: ping-pong, 2 banks x {p,n} x {re,im} x 64 x 23 bit; a completed block is queued with its two shift values.
// - Output: 1 cycle after the edge capturing beat 4, valid_out=1 for 8 consecutive cycles.
//   - cycles 1..4 = p beats 0..3; cycles 5..8 = n beats 0..3.
// - Per sample: y = (x <<< s)[22:12], s = that stream's block shift.
// - If a second block completes during playback, it plays immediately after the first (no idle cycle).
// - Throughput: at most one block per 8 cycles. Exceeding this (3rd block arriving before the 1st finishes) is unsupported; output contents undefined.
// - When valid_out=0, dout_mux_* hold 0.
// - Mid-block reset discards the partial block; the next valid beat is beat 0.
// CONFIGURATION
// - CBFP_ROUND_EN defined: add 1<<11 to (x<<<s) before taking [22:12]; saturate to +1023/-1024.
// - CBFP_ROUND_EN undefined: plain truncation, no saturation logic. Latency identical either way.
// TESTING
// - Reset: rstn=0 mid-stream -> valid_out=0, dout_mux_*=0 immediately; next block starts at beat 0.
// - p re/im all 1000, n all -1000 -> s=12 both; 4 beats out 1000, then 4 beats out -1000.
// - One p sample 2097152, rest of p =4096 -> s=0; outputs 512 and 1. n all 0 -> s=22, outputs 0.
// - p re lane0 = -4194304 -> s=0, output -1024; lanes equal to 4095 output 0 (truncate).
// - valid_in pattern 4 on / 4 off x4, then 8 on / 8 off -> each block yields exactly 8 valid_out cycles, back-to-back blocks contiguous, order p,n.
// - CBFP_ROUND_EN: x=2099200, s=0 -> 513 (trunc 512); x=4194303 -> 1023 (saturated).

Source files
------------

// File: rtl/cbfp_stage0.sv
// CBFP stage-0 normaliser: per-block minimum sign-bit shift of the p and n streams, replayed p then n (CBFP_ROUND_EN: round + saturate).
// Latency: first output beat one cycle after the edge capturing the 4th beat of a block; 8 contiguous output beats per block.
// Backpressure: none; sustains one block per 8 cycles, a third block arriving before the first has drained is unsupported.
module cbfp_stage0 #(
    parameter int cnt_size     = 5,
    parameter int array_size   = 16,
    parameter int din_size     = 23,
    parameter int dout_size    = 11,
    parameter int buffer_depth = 64
) (
    input  logic                                   clk,
    input  logic                                   rstn,
    input  logic                                   valid_in,
    input  logic [array_size-1:0][din_size-1:0]    din_re_p,
    input  logic [array_size-1:0][din_size-1:0]    din_im_p,
    input  logic [array_size-1:0][din_size-1:0]    din_re_n,
    input  logic [array_size-1:0][din_size-1:0]    din_im_n,
    output logic [array_size-1:0][dout_size-1:0]   dout_mux_re,
    output logic [array_size-1:0][dout_size-1:0]   dout_mux_im,
    output logic                                   valid_out
);

    localparam int addr_w = $clog2(buffer_depth);
    localparam int drop_w = din_size - dout_size;
    localparam logic [cnt_size-1:0] cnt_max = cnt_size'(din_size - 1);

    // Redundant sign bits: leading bits equal to the MSB, minus one (0 and -1 give din_size-1).
    function automatic logic [cnt_size-1:0] rsb_count(input logic [din_size-1:0] x);
        logic [cnt_size-1:0] cnt;
        logic                found;
        cnt   = cnt_max;
        found = 1'b0;
        for (int i = din_size - 2; i >= 0; i--) begin
            if (!found && (x[i] != x[din_size-1])) begin
                cnt   = cnt_size'(din_size - 2 - i);
                found = 1'b1;
            end
        end
        return cnt;
    endfunction

    function automatic logic [cnt_size-1:0] cnt_min(input logic [cnt_size-1:0] a,
                                                    input logic [cnt_size-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [dout_size-1:0] normalise(input logic [din_size-1:0] x,
                                                      input logic [cnt_size-1:0] s);
        logic [din_size-1:0] sh;
`ifdef CBFP_ROUND_EN
        logic [din_size:0]   rnd;
        logic [dout_size:0]  q;
`endif
        sh = x << s;
`ifdef CBFP_ROUND_EN
        rnd = {sh[din_size-1], sh} + ((din_size+1)'(1) << (drop_w - 1));
        q   = (dout_size+1)'(rnd >> drop_w);
        // Rounding can only overflow upward, from the largest positive inputs.
        if (!q[dout_size] && q[dout_size-1])
            normalise = {1'b0, {(dout_size-1){1'b1}}};
        else
            normalise = dout_size'(q);
`else
        normalise = dout_size'(sh >> drop_w);
`endif
        return normalise;
    endfunction

    logic [1:0]                 beat_cnt;
    logic                       blk_done;
    logic [cnt_size-1:0]        run_min_p, run_min_n;
    logic [cnt_size-1:0]        beat_min_p, beat_min_n;
    logic [cnt_size-1:0]        blk_min_p, blk_min_n;
    logic                       wr_bank, rd_bank;
    logic [1:0]                 full;
    logic [cnt_size-1:0]        shift_p [2];
    logic [cnt_size-1:0]        shift_n [2];
    logic [2:0]                 play_cnt;
    logic                       rd_sel_n;
    logic [cnt_size-1:0]        rd_shift;
    logic [array_size-1:0][dout_size-1:0] play_re, play_im;

    logic [din_size-1:0] buf_re_p [2][buffer_depth];
    logic [din_size-1:0] buf_im_p [2][buffer_depth];
    logic [din_size-1:0] buf_re_n [2][buffer_depth];
    logic [din_size-1:0] buf_im_n [2][buffer_depth];

    assign blk_done = valid_in && (beat_cnt == 2'd3);

    always_comb begin
        beat_min_p = cnt_max;
        beat_min_n = cnt_max;
        for (int l = 0; l < array_size; l++) begin
            beat_min_p = cnt_min(beat_min_p, rsb_count(din_re_p[l]));
            beat_min_p = cnt_min(beat_min_p, rsb_count(din_im_p[l]));
            beat_min_n = cnt_min(beat_min_n, rsb_count(din_re_n[l]));
            beat_min_n = cnt_min(beat_min_n, rsb_count(din_im_n[l]));
        end
        blk_min_p = cnt_min(run_min_p, beat_min_p);
        blk_min_n = cnt_min(run_min_n, beat_min_n);
    end

    always_ff @(posedge clk) begin
        if (valid_in) begin
            for (int l = 0; l < array_size; l++) begin
                buf_re_p[wr_bank][addr_w'(int'(beat_cnt) * array_size + l)] <= din_re_p[l];
                buf_im_p[wr_bank][addr_w'(int'(beat_cnt) * array_size + l)] <= din_im_p[l];
                buf_re_n[wr_bank][addr_w'(int'(beat_cnt) * array_size + l)] <= din_re_n[l];
                buf_im_n[wr_bank][addr_w'(int'(beat_cnt) * array_size + l)] <= din_im_n[l];
            end
        end
    end

    // play_cnt[2] selects the n stream, play_cnt[1:0] is the beat being replayed.
    assign rd_sel_n = play_cnt[2];
    assign rd_shift = rd_sel_n ? shift_n[rd_bank] : shift_p[rd_bank];

    always_comb begin
        play_re = '0;
        play_im = '0;
        for (int l = 0; l < array_size; l++) begin
            if (rd_sel_n) begin
                play_re[l] = normalise(buf_re_n[rd_bank][addr_w'(int'(play_cnt[1:0]) * array_size + l)], rd_shift);
                play_im[l] = normalise(buf_im_n[rd_bank][addr_w'(int'(play_cnt[1:0]) * array_size + l)], rd_shift);
            end else begin
                play_re[l] = normalise(buf_re_p[rd_bank][addr_w'(int'(play_cnt[1:0]) * array_size + l)], rd_shift);
                play_im[l] = normalise(buf_im_p[rd_bank][addr_w'(int'(play_cnt[1:0]) * array_size + l)], rd_shift);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beat_cnt    <= 2'd0;
            run_min_p   <= cnt_max;
            run_min_n   <= cnt_max;
            wr_bank     <= 1'b0;
            rd_bank     <= 1'b0;
            full        <= 2'b00;
            shift_p[0]  <= cnt_max;
            shift_p[1]  <= cnt_max;
            shift_n[0]  <= cnt_max;
            shift_n[1]  <= cnt_max;
            play_cnt    <= 3'd0;
            valid_out   <= 1'b0;
            dout_mux_re <= '0;
            dout_mux_im <= '0;
        end else begin
            if (valid_in) begin
                beat_cnt <= beat_cnt + 2'd1;
                if (blk_done) begin
                    run_min_p          <= cnt_max;
                    run_min_n          <= cnt_max;
                    shift_p[wr_bank]   <= blk_min_p;
                    shift_n[wr_bank]   <= blk_min_n;
                    wr_bank            <= ~wr_bank;
                end else begin
                    run_min_p <= blk_min_p;
                    run_min_n <= blk_min_n;
                end
            end

            // A bank queued while the other drains is picked up on the very next cycle.
            if (full[rd_bank]) begin
                valid_out   <= 1'b1;
                dout_mux_re <= play_re;
                dout_mux_im <= play_im;
                play_cnt    <= play_cnt + 3'd1;
                if (play_cnt == 3'd7) begin
                    full[rd_bank] <= 1'b0;
                    rd_bank       <= ~rd_bank;
                end
            end else begin
                valid_out   <= 1'b0;
                dout_mux_re <= '0;
                dout_mux_im <= '0;
            end

            if (blk_done)
                full[wr_bank] <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cbfp_stage0.sv
// Directed bench for cbfp_stage0: block vectors from a table plus reset and throughput sequences.
module tb_cbfp_stage0;

`ifdef CBFP_ROUND_EN
    localparam int rnd = 1;
`else
    localparam int rnd = 0;
`endif

    typedef struct {
        int p_base;
        int n_base;
        int sp_val;
        bit sp_n;
        bit sp_im;
        int sp_beat;
        int sp_lane;
        int exp_p;
        int exp_n;
        int exp_sp;
    } vec_t;

    logic                   clk;
    logic                   rstn;
    logic                   valid_in;
    logic [15:0][22:0]      din_re_p, din_im_p, din_re_n, din_im_n;
    logic [15:0][10:0]      dout_mux_re, dout_mux_im;
    logic                   valid_out;

    int   n_checks;
    int   n_pass;
    bit   mon_en;
    int   cur_run;
    int   runs[$];
    int   exp_q[$];
    int   mon_e;
    vec_t vecs[7];

    cbfp_stage0 dut (
        .clk        (clk),
        .rstn       (rstn),
        .valid_in   (valid_in),
        .din_re_p   (din_re_p),
        .din_im_p   (din_im_p),
        .din_re_n   (din_re_n),
        .din_im_n   (din_im_n),
        .dout_mux_re(dout_mux_re),
        .dout_mux_im(dout_mux_im),
        .valid_out  (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [175:0] act, input logic [175:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic logic [175:0] all_lanes(input int v);
        logic [15:0][10:0] e;
        for (int l = 0; l < 16; l++)
            e[l] = 11'(v);
        return e;
    endfunction

    function automatic logic [175:0] exp_bus(input vec_t v, input int k, input bit im);
        logic [15:0][10:0] e;
        bit is_n;
        int b;
        is_n = (k >= 4);
        b    = k % 4;
        for (int l = 0; l < 16; l++) begin
            e[l] = 11'(is_n ? v.exp_n : v.exp_p);
            if (v.sp_n == is_n && v.sp_im == im && v.sp_beat == b && v.sp_lane == l)
                e[l] = 11'(v.exp_sp);
        end
        return e;
    endfunction

    task automatic set_all(input int pv, input int nv);
        for (int l = 0; l < 16; l++) begin
            din_re_p[l] = 23'(pv);
            din_im_p[l] = 23'(pv);
            din_re_n[l] = 23'(nv);
            din_im_n[l] = 23'(nv);
        end
    endtask

    task automatic set_beat(input vec_t v, input int b);
        set_all(v.p_base, v.n_base);
        if (b == v.sp_beat) begin
            case ({v.sp_n, v.sp_im})
                2'b00:   din_re_p[v.sp_lane] = 23'(v.sp_val);
                2'b01:   din_im_p[v.sp_lane] = 23'(v.sp_val);
                2'b10:   din_re_n[v.sp_lane] = 23'(v.sp_val);
                default: din_im_n[v.sp_lane] = 23'(v.sp_val);
            endcase
        end
    endtask

    // Four consecutive beats; returns at the falling edge after the 4th beat is captured.
    task automatic drive_vec(input vec_t v);
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            valid_in = 1'b1;
            set_beat(v, b);
        end
        @(negedge clk);
        valid_in = 1'b0;
        set_all(0, 0);
    endtask

    task automatic expect_vec(input vec_t v, input string tag);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("%s out%0d valid", tag, k), valid_out, 1);
            chk($sformatf("%s out%0d re", tag, k), dout_mux_re, exp_bus(v, k, 1'b0));
            chk($sformatf("%s out%0d im", tag, k), dout_mux_im, exp_bus(v, k, 1'b1));
        end
        @(negedge clk);
        chk($sformatf("%s idle valid", tag), valid_out, 0);
        chk($sformatf("%s idle re", tag), dout_mux_re, 0);
        chk($sformatf("%s idle im", tag), dout_mux_im, 0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (valid_out) begin
                cur_run++;
                if (exp_q.size() == 0) begin
                    chk("unexpected beat", valid_out, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("stream re", dout_mux_re, all_lanes(mon_e));
                    chk("stream im", dout_mux_im, all_lanes(mon_e));
                end
            end else if (cur_run > 0) begin
                runs.push_back(cur_run);
                cur_run = 0;
            end
        end
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        mon_en   = 1'b0;
        cur_run  = 0;
        rstn     = 1'b0;
        valid_in = 1'b0;
        set_all(0, 0);

        vecs[0] = '{p_base:1000,    n_base:-1000, sp_val:1000,     sp_n:0, sp_im:0, sp_beat:0, sp_lane:0,
                    exp_p:1000,       exp_n:-1000, exp_sp:1000};
        vecs[1] = '{p_base:4096,    n_base:0,     sp_val:2097152,  sp_n:0, sp_im:0, sp_beat:0, sp_lane:0,
                    exp_p:1,          exp_n:0,     exp_sp:512};
        vecs[2] = '{p_base:4095,    n_base:0,     sp_val:-4194304, sp_n:0, sp_im:0, sp_beat:2, sp_lane:5,
                    exp_p:rnd,        exp_n:0,     exp_sp:-1024};
        vecs[3] = '{p_base:-1,      n_base:1,     sp_val:-1,       sp_n:0, sp_im:0, sp_beat:1, sp_lane:1,
                    exp_p:-1024,      exp_n:512,   exp_sp:-1024};
        vecs[4] = '{p_base:2099200, n_base:0,     sp_val:4194303,  sp_n:0, sp_im:0, sp_beat:3, sp_lane:15,
                    exp_p:512 + rnd,  exp_n:0,     exp_sp:1023};
        vecs[5] = '{p_base:1000,    n_base:7,     sp_val:2097152,  sp_n:0, sp_im:1, sp_beat:1, sp_lane:9,
                    exp_p:0,          exp_n:896,   exp_sp:512};
        vecs[6] = '{p_base:0,       n_base:1000,  sp_val:-2097152, sp_n:1, sp_im:1, sp_beat:3, sp_lane:3,
                    exp_p:0,          exp_n:0,     exp_sp:-1024};

        repeat (3) @(negedge clk);
        chk("reset valid_out", valid_out, 0);
        chk("reset re", dout_mux_re, 0);
        chk("reset im", dout_mux_im, 0);
        rstn = 1'b1;

        for (int i = 0; i < 7; i++) begin
            drive_vec(vecs[i]);
            chk($sformatf("vec%0d latency", i), valid_out, 0);
            expect_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Reset during playback with a second block half written.
        drive_vec(vecs[0]);
        @(negedge clk);
        @(negedge clk);
        valid_in = 1'b1;
        set_beat(vecs[5], 0);
        @(negedge clk);
        set_beat(vecs[5], 1);
        @(negedge clk);
        valid_in = 1'b0;
        set_all(0, 0);
        chk("pre-reset valid", valid_out, 1);
        rstn = 1'b0;
        #1;
        chk("midreset valid", valid_out, 0);
        chk("midreset re", dout_mux_re, 0);
        chk("midreset im", dout_mux_im, 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        chk("post-reset idle", valid_out, 0);
        drive_vec(vecs[1]);
        chk("post-reset latency", valid_out, 0);
        expect_vec(vecs[1], "post-reset");

        // 4 on / 4 off four times, then 8 on: playback must be one unbroken run.
        mon_en = 1'b1;
        for (int j = 0; j < 6; j++) begin
            for (int b = 0; b < 4; b++) begin
                @(negedge clk);
                valid_in = 1'b1;
                set_all(550 + 40 * j, -(600 + 40 * j));
            end
            for (int k = 0; k < 4; k++) exp_q.push_back(550 + 40 * j);
            for (int k = 0; k < 4; k++) exp_q.push_back(-(600 + 40 * j));
            if (j < 4) begin
                @(negedge clk);
                valid_in = 1'b0;
                repeat (3) @(negedge clk);
            end
        end
        @(negedge clk);
        valid_in = 1'b0;
        set_all(0, 0);
        repeat (24) @(negedge clk);
        mon_en = 1'b0;
        chk("run count", runs.size(), 1);
        chk("run length", (runs.size() > 0) ? runs[0] : 0, 48);
        chk("queue drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
